// File: rtl/cntr_n_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cntr_n_if
// Brief   : Control/data bundle for the cntr_n loadable up/down counter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface cntr_n_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             load;
   logic             inc;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic [2:0]       o_state;
   logic             o_bound;

   modport master (
      output en, load, inc, d_in,
      input  d_out, o_state, o_bound
   );

   modport slave (
      input  en, load, inc, d_in,
      output d_out, o_state, o_bound
   );
endinterface
`default_nettype wire

// File: rtl/cntr_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cntr_n
// Brief   : Parametrised loadable up/down counter, six-state phase FSM,
//           wrap or saturate arithmetic and a registered boundary flag.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module cntr_n #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  wire          clk,
   input  wire          reset,
   cntr_n_if.slave      bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'b000,
      S_LOAD = 3'b001,
      S_INC  = 3'b010,
      S_INC2 = 3'b011,
      S_DEC  = 3'b100,
      S_DEC2 = 3'b101
   } state_t;

   localparam logic [WIDTH-1:0] c_CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] c_CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             bound_q, bound_d;
   logic             w_illegal;

   assign w_illegal = (state_q == state_t'(3'b110)) || (state_q == state_t'(3'b111));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= c_CNT_ZERO;
         bound_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bound_q <= bound_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bound_d = 1'b0;
      // An unreachable code is scrubbed back to IDLE even while disabled.
      if (w_illegal) begin
         state_d = S_IDLE;
      end else if (bus.en) begin
         if (bus.load) begin
            state_d = S_LOAD;
            count_d = bus.d_in;
         end else if (bus.inc) begin
            state_d = (state_q == S_INC) ? S_INC2 : S_INC;
            if (count_q == c_CNT_MAX) begin
               bound_d = 1'b1;
               count_d = SATURATE ? c_CNT_MAX : c_CNT_ZERO;
            end else begin
               count_d = count_q + c_CNT_ONE;
            end
         end else begin
            state_d = (state_q == S_DEC) ? S_DEC2 : S_DEC;
            if (count_q == c_CNT_ZERO) begin
               bound_d = 1'b1;
               count_d = SATURATE ? c_CNT_ZERO : c_CNT_MAX;
            end else begin
               count_d = count_q - c_CNT_ONE;
            end
         end
      end
   end

   assign bus.d_out   = count_q;
   assign bus.o_state = state_q;
   assign bus.o_bound = bound_q;

endmodule
`default_nettype wire
